fft_bitrev_reorder: RTL and testbench

Output reorder buffer that sits directly downstream of the last SDF butterfly stage of the 64-point FFT. The SDF pipeline delivers each frame in bit-reversed bin order. This block collects one complete frame into a ping-pong buffer, writing each sample at its bit-reversed address. It then streams the frame out in natural bin order (bin 0 first) with a valid/start-of-frame marker.

---
 rtl/fft_bitrev_reorder_if.sv | 26 ++
 rtl/fft_bitrev_reorder.sv | 137 +++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_if.sv
// rtl/fft_bitrev_reorder_if.sv - sample stream bundle between the last SDF stage, the reorder buffer and its consumer
// master drives the bit-reversed input stream; slave is the reorder buffer producing natural-order output.
interface fft_bitrev_reorder_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_W     = 6
);
    logic                         in_valid;
    logic                         in_sof;
    logic signed [DATA_WIDTH-1:0] serial_in_r;
    logic signed [DATA_WIDTH-1:0] serial_in_i;
    logic                         out_valid;
    logic                         out_sof;
    logic        [ADDR_W-1:0]     out_index;
    logic signed [DATA_WIDTH-1:0] serial_out_r;
    logic signed [DATA_WIDTH-1:0] serial_out_i;

    modport master (
        output in_valid, in_sof, serial_in_r, serial_in_i,
        input  out_valid, out_sof, out_index, serial_out_r, serial_out_i
    );

    modport slave (
        input  in_valid, in_sof, serial_in_r, serial_in_i,
        output out_valid, out_sof, out_index, serial_out_r, serial_out_i
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong buffer turning bit-reversed FFT frames into natural bin order
// Frames are written at bitrev(count) into one bank while the other bank streams out sequentially.
module fft_bitrev_reorder #(
    parameter int INTEGER_SIZE = 6,
    parameter int FRACT_SIZE   = 12,
    parameter int NFFT         = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_bitrev_reorder_if.slave  bus
);
    localparam int DATA_WIDTH = INTEGER_SIZE + FRACT_SIZE;
    localparam int ADDR_W     = $clog2(NFFT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NFFT - 1);

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic        [ADDR_W-1:0]     r_wr_cnt;
    logic        [ADDR_W-1:0]     r_rd_cnt;
    logic        [ADDR_W-1:0]     w_rd_cnt_nxt;
    logic                         r_wr_bank;
    logic                         r_rd_bank;
    logic        [ADDR_W-1:0]     w_wr_addr;
    logic                         w_frame_done;

    logic signed [DATA_WIDTH-1:0] r_mem_r [0:2*NFFT-1];
    logic signed [DATA_WIDTH-1:0] r_mem_i [0:2*NFFT-1];

    logic                         r_out_valid;
    logic                         r_out_sof;
    logic        [ADDR_W-1:0]     r_out_index;
    logic signed [DATA_WIDTH-1:0] r_out_r;
    logic signed [DATA_WIDTH-1:0] r_out_i;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] res;
        for (int b = 0; b < ADDR_W; b++) begin
            res[b] = a[ADDR_W-1-b];
        end
        return res;
    endfunction

    // A start-of-frame sample always lands at address 0 and is never the closing sample.
    always_comb begin
        w_wr_addr    = bus.in_sof ? '0 : bitrev(r_wr_cnt);
        w_frame_done = bus.in_valid && !bus.in_sof && (r_wr_cnt == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            r_mem_r[{r_wr_bank, w_wr_addr}] <= bus.serial_in_r;
            r_mem_i[{r_wr_bank, w_wr_addr}] <= bus.serial_in_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else if (bus.in_valid) begin
            if (bus.in_sof) begin
                r_wr_cnt <= ADDR_W'(1);
            end else begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_frame_done) begin
                r_wr_bank <= ~r_wr_bank;
                r_rd_bank <= r_wr_bank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rd_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
        end
    end

    // A completion on the last read edge chains straight into the next frame with no gap.
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_cnt_nxt = r_rd_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_frame_done) begin
                    w_state_nxt  = S_READ;
                    w_rd_cnt_nxt = '0;
                end
            end
            S_READ: begin
                w_rd_cnt_nxt = r_rd_cnt + 1'b1;
                if ((r_rd_cnt == LAST_IDX) && !w_frame_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_rd_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_index <= '0;
            r_out_r     <= '0;
            r_out_i     <= '0;
        end else if (r_state == S_READ) begin
            r_out_valid <= 1'b1;
            r_out_sof   <= (r_rd_cnt == '0);
            r_out_index <= r_rd_cnt;
            r_out_r     <= r_mem_r[{r_rd_bank, r_rd_cnt}];
            r_out_i     <= r_mem_i[{r_rd_bank, r_rd_cnt}];
        end else begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_sof      = r_out_sof;
    assign bus.out_index    = r_out_index;
    assign bus.serial_out_r = r_out_r;
    assign bus.serial_out_i = r_out_i;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - randomized self-checking bench for fft_bitrev_reorder
// A frame-level model predicts each natural-order bin and the cycle it must appear on.
module tb_fft_bitrev_reorder;
    localparam int NFFT = 64;
    localparam int DW   = 18;
    localparam int AW   = 6;

    typedef struct {
        int                   cyc;
        int                   idx;
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    fft_bitrev_reorder #(
        .INTEGER_SIZE(6),
        .FRACT_SIZE  (12),
        .NFFT        (NFFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t                 exp_q[$];
    logic signed [DW-1:0] frm_r [NFFT];
    logic signed [DW-1:0] frm_i [NFFT];
    int                   frm_cnt = 0;
    int                   cyc = 0;
    int                   checks = 0;
    int                   errors = 0;
    int                   vld_cnt = 0;
    int                   sof_cnt = 0;
    bit                   lit_mode = 1'b0;
    int                   lit_r [4];

    function automatic int bitrev_m(input int a);
        int res = 0;
        int v = a;
        for (int b = 0; b < AW; b++) begin
            res = res * 2 + (v % 2);
            v = v / 2;
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Collect input-order samples; a full frame yields bin k = input sample bitrev(k), one per cycle.
    task automatic model_update();
        if (rst) begin
            exp_q.delete();
            frm_cnt = 0;
        end else if (bus.in_valid) begin
            if (bus.in_sof) frm_cnt = 0;
            frm_r[frm_cnt] = bus.serial_in_r;
            frm_i[frm_cnt] = bus.serial_in_i;
            frm_cnt++;
            if (frm_cnt == NFFT) begin
                for (int k = 0; k < NFFT; k++) begin
                    exp_q.push_back('{cyc + 1 + k, k, frm_r[bitrev_m(k)], frm_i[bitrev_m(k)]});
                end
                frm_cnt = 0;
            end
        end
    endtask

    task automatic compare();
        exp_t e;
        if (rst) begin
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_sof", bus.out_sof, 0);
            chk("rst_index", bus.out_index, 0);
            chk("rst_r", bus.serial_out_r, 0);
            chk("rst_i", bus.serial_out_i, 0);
        end else if (bus.out_valid) begin
            vld_cnt++;
            if (bus.out_sof) sof_cnt++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_index", bus.out_index, e.idx);
                chk("out_r", bus.serial_out_r, e.r);
                chk("out_i", bus.serial_out_i, e.i);
                chk("out_sof", bus.out_sof, (e.idx == 0) ? 1 : 0);
                if (lit_mode && e.idx < 4) chk("lit_bin_r", bus.serial_out_r, lit_r[e.idx]);
                if (lit_mode && e.idx == 63) chk("lit_bin63_i", bus.serial_out_i, -63);
            end
        end else begin
            chk("idle_sof", bus.out_sof, 0);
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                chk("missing_output", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit v, input bit s, input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
        bus.in_valid    = v;
        bus.in_sof      = s;
        bus.serial_in_r = r;
        bus.serial_in_i = i;
        step();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 1'(($urandom % 2)), DW'($urandom), DW'($urandom));
    endtask

    task automatic rand_frame();
        for (int k = 0; k < NFFT; k++) drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
    endtask

    task automatic window_check(input string name, input int v0, input int s0, input int nv, input int ns);
        chk({name, "_valid_cycles"}, vld_cnt - v0, nv);
        chk({name, "_sof_pulses"}, sof_cnt - s0, ns);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int  v0;
        int  s0;
        bit  found;
        lit_r = '{0, 32, 16, 48};
        bus.in_valid    = 1'b0;
        bus.in_sof      = 1'b0;
        bus.serial_in_r = '0;
        bus.serial_in_i = '0;

        chk("model_bitrev1", bitrev_m(1), 32);
        chk("model_bitrev3", bitrev_m(3), 48);
        chk("model_bitrev6", bitrev_m(6), 24);

        for (int c = 0; c < 3; c++) drive(1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom));
        #2 rst = 1'b0;
        #1 compare();
        v0 = vld_cnt; s0 = sof_cnt;
        idle(5);
        window_check("post_reset", v0, s0, 0, 0);

        lit_mode = 1'b1;
        v0 = vld_cnt; s0 = sof_cnt;
        for (int k = 0; k < NFFT; k++) drive(1'b1, k == 0, DW'(k), DW'(-k));
        idle(70);
        window_check("single", v0, s0, 64, 1);
        lit_mode = 1'b0;

        v0 = vld_cnt; s0 = sof_cnt;
        for (int f = 0; f < 3; f++) rand_frame();
        idle(70);
        window_check("b2b", v0, s0, 192, 3);

        v0 = vld_cnt; s0 = sof_cnt;
        for (int k = 0; k < NFFT; k++) begin
            drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
            drive(1'b0, 1'($urandom), DW'($urandom), DW'($urandom));
        end
        idle(70);
        window_check("gapped", v0, s0, 64, 1);

        v0 = vld_cnt; s0 = sof_cnt;
        for (int k = 0; k < 20; k++) drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
        rand_frame();
        idle(70);
        window_check("resync", v0, s0, 64, 1);

        rand_frame();
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            idle(1);
            if (bus.out_valid && bus.out_index == AW'(10)) found = 1'b1;
        end
        chk("reach_index10", found, 1);
        rst = 1'b1;
        #1 compare();
        idle(2);
        #2 rst = 1'b0;
        v0 = vld_cnt; s0 = sof_cnt;
        idle(20);
        window_check("after_rst", v0, s0, 0, 0);
        v0 = vld_cnt; s0 = sof_cnt;
        rand_frame();
        idle(70);
        window_check("post_rst_frame", v0, s0, 64, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
